// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: ROM address/data, the valid/ready instruction
// channel towards decode, and the PC redirect channel from execute.
interface fetch_unit_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 12
);
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;

    // Fetch unit side.
    modport master (
        output rom_addr, instr, instr_pc, instr_valid,
        input  rom_data, instr_ready, redirect_valid, redirect_addr
    );

    // ROM / decode / execute side.
    modport slave (
        input  rom_addr, instr, instr_pc, instr_valid,
        output rom_data, instr_ready, redirect_valid, redirect_addr
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Owns the PC, addresses the combinational ROM,
// resolves JMP and HLT locally and hands every other word (with its PC)
// to decode over valid/ready. Execute may redirect the PC at any time
// outside IDLE; a redirect also wakes the unit from HALTED.
module fetch_unit #(
    parameter int                ADDR_W     = 8,
    parameter int                DATA_W     = 12,
    parameter int                OPC_W      = 4,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [OPC_W-1:0]  JMP_OP     = 4'h4,
    parameter logic [OPC_W-1:0]  HLT_OP     = 4'hF,
    parameter int                CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    fetch_unit_if.master     bus,
    output logic             halted,
    output logic             busy,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [ADDR_W-1:0] pc_reg,       pc_next;
    logic [DATA_W-1:0] instr_reg,    instr_next;
    logic [ADDR_W-1:0] instr_pc_reg, instr_pc_next;
    logic              valid_reg,    valid_next;
    logic [CNT_W-1:0]  cnt_reg,      cnt_next;

    logic [OPC_W-1:0]  opcode;
    logic [ADDR_W-1:0] operand;
    logic              slot_free;
    logic              is_jmp;
    logic              is_hlt;

    assign opcode    = bus.rom_data[DATA_W-1 -: OPC_W];
    assign operand   = bus.rom_data[ADDR_W-1:0];
    assign is_jmp    = (opcode == JMP_OP);
    assign is_hlt    = (opcode == HLT_OP);
    // The output slot can take a new word if it is empty or being drained now.
    assign slot_free = !valid_reg || bus.instr_ready;

    assign bus.rom_addr    = pc_reg;
    assign bus.instr       = instr_reg;
    assign bus.instr_pc    = instr_pc_reg;
    assign bus.instr_valid = valid_reg;
    assign fetch_count     = cnt_reg;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: a redirect always wins over a halt in the same cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!bus.redirect_valid && slot_free && !is_jmp && is_hlt) begin
                    state_next = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (bus.redirect_valid) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        halted = 1'b0;
        busy   = 1'b0;
        case (state_reg)
            ST_RUN:    busy   = 1'b1;
            ST_HALTED: halted = 1'b1;
            default: begin
                halted = 1'b0;
                busy   = 1'b0;
            end
        endcase
    end

    // Datapath next values: redirect, then stall, then JMP, then HLT, then emit.
    always_comb begin
        pc_next       = pc_reg;
        instr_next    = instr_reg;
        instr_pc_next = instr_pc_reg;
        valid_next    = valid_reg;
        cnt_next      = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    pc_next = START_ADDR;
                end
            end
            ST_RUN: begin
                if (bus.redirect_valid) begin
                    pc_next    = bus.redirect_addr;
                    valid_next = 1'b0;
                end else if (!slot_free) begin
                    valid_next = 1'b1;
                end else if (is_jmp) begin
                    pc_next    = operand;
                    valid_next = 1'b0;
                end else if (is_hlt) begin
                    valid_next = 1'b0;
                end else begin
                    instr_next    = bus.rom_data;
                    instr_pc_next = pc_reg;
                    valid_next    = 1'b1;
                    pc_next       = pc_reg + ADDR_W'(1);
                    if (cnt_reg != {CNT_W{1'b1}}) begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end
            ST_HALTED: begin
                if (bus.redirect_valid) begin
                    pc_next    = bus.redirect_addr;
                    valid_next = 1'b0;
                end
            end
            default: valid_next = 1'b0;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg       <= START_ADDR;
            instr_reg    <= '0;
            instr_pc_reg <= '0;
            valid_reg    <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            pc_reg       <= pc_next;
            instr_reg    <= instr_next;
            instr_pc_reg <= instr_pc_next;
            valid_reg    <= valid_next;
            cnt_reg      <= cnt_next;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: vector table for the straight-line, backpressure
// and redirect-in-stall cases, directed sequences for halt, wrap, reset,
// start-in-RUN and counter saturation, then random traffic checked against
// an instruction-stream model that walks the ROM program.
module tb_fetch_unit;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 12;
    localparam int CNT_W  = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic halted, busy;
    logic [CNT_W-1:0] fetch_count;

    logic [DATA_W-1:0] rom [256];

    int n_checks = 0;
    int n_errors = 0;

    fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    assign bus.rom_data = rom[bus.rom_addr];

    fetch_unit #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .bus         (bus.master),
        .halted      (halted),
        .busy        (busy),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          restart;
        bit          ready;
        bit          redir;
        logic [7:0]  raddr;
        bit          ev;
        logic [11:0] ei;
        logic [7:0]  ep;
        logic [7:0]  era;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(bit rs, bit rd, bit rv, logic [7:0] ra, bit ev,
                                logic [11:0] ei, logic [7:0] ep, logic [7:0] era);
        vec_t v;
        v.restart = rs; v.ready = rd; v.redir = rv; v.raddr = ra;
        v.ev = ev; v.ei = ei; v.ep = ep; v.era = era;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = 8'h00;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic load_prog1();
        logic [11:0] p [13];
        p = '{12'h800, 12'h600, 12'h801, 12'h601, 12'h700, 12'h001, 12'h602,
              12'h701, 12'h600, 12'h702, 12'h601, 12'hA00, 12'h404};
        for (int i = 0; i < 256; i++) rom[i] = 12'h000;
        for (int i = 0; i < 13; i++) rom[i] = p[i];
    endtask

    // Program walk: from address 'from', follow jumps to the next word that
    // would be emitted. Returns 1 = emit at 'at', 2 = halt at 'at', 0 = spin.
    function automatic int walk_peek(input logic [7:0] from, output logic [7:0] at);
        logic [7:0] p;
        p = from;
        for (int s = 0; s < 300; s++) begin
            if (rom[p][11:8] == 4'h4) begin
                p = rom[p][7:0];
            end else begin
                at = p;
                return (rom[p][11:8] == 4'hF) ? 2 : 1;
            end
        end
        at = p;
        return 0;
    endfunction

    initial begin
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = 8'h00;
        load_prog1();

        // Reset state
        #12;
        chk("rst_valid", 32'(bus.instr_valid), 0);
        chk("rst_instr", 32'(bus.instr), 0);
        chk("rst_instr_pc", 32'(bus.instr_pc), 0);
        chk("rst_rom_addr", 32'(bus.rom_addr), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(fetch_count), 0);
        rst_n = 1'b1;

        // Redirect in IDLE is ignored
        bus.redirect_valid = 1'b1; bus.redirect_addr = 8'h33;
        step();
        bus.redirect_valid = 1'b0;
        chk("idle_redirect_ignored", 32'(bus.rom_addr), 0);
        chk("idle_busy", 32'(busy), 0);

        // Test 1: straight run, jump bubble, loop
        tbl.push_back(mk(1,1,0,0, 1,12'h800,8'h00,8'h01));
        tbl.push_back(mk(0,1,0,0, 1,12'h600,8'h01,8'h02));
        tbl.push_back(mk(0,1,0,0, 1,12'h801,8'h02,8'h03));
        tbl.push_back(mk(0,1,0,0, 1,12'h601,8'h03,8'h04));
        tbl.push_back(mk(0,1,0,0, 1,12'h700,8'h04,8'h05));
        tbl.push_back(mk(0,1,0,0, 1,12'h001,8'h05,8'h06));
        tbl.push_back(mk(0,1,0,0, 1,12'h602,8'h06,8'h07));
        tbl.push_back(mk(0,1,0,0, 1,12'h701,8'h07,8'h08));
        tbl.push_back(mk(0,1,0,0, 1,12'h600,8'h08,8'h09));
        tbl.push_back(mk(0,1,0,0, 1,12'h702,8'h09,8'h0A));
        tbl.push_back(mk(0,1,0,0, 1,12'h601,8'h0A,8'h0B));
        tbl.push_back(mk(0,1,0,0, 1,12'hA00,8'h0B,8'h0C));
        tbl.push_back(mk(0,1,0,0, 0,12'h000,8'h00,8'h04));
        tbl.push_back(mk(0,1,0,0, 1,12'h700,8'h04,8'h05));
        tbl.push_back(mk(0,1,0,0, 1,12'h001,8'h05,8'h06));
        tbl.push_back(mk(0,1,0,0, 1,12'h602,8'h06,8'h07));
        tbl.push_back(mk(0,1,0,0, 1,12'h701,8'h07,8'h08));
        tbl.push_back(mk(0,1,0,0, 1,12'h600,8'h08,8'h09));
        tbl.push_back(mk(0,1,0,0, 1,12'h702,8'h09,8'h0A));
        tbl.push_back(mk(0,1,0,0, 1,12'h601,8'h0A,8'h0B));
        tbl.push_back(mk(0,1,0,0, 1,12'hA00,8'h0B,8'h0C));
        tbl.push_back(mk(0,1,0,0, 0,12'h000,8'h00,8'h04));
        tbl.push_back(mk(0,1,0,0, 1,12'h700,8'h04,8'h05));
        // Test 2: backpressure on 0x801
        tbl.push_back(mk(1,1,0,0, 1,12'h800,8'h00,8'h01));
        tbl.push_back(mk(0,1,0,0, 1,12'h600,8'h01,8'h02));
        tbl.push_back(mk(0,1,0,0, 1,12'h801,8'h02,8'h03));
        tbl.push_back(mk(0,0,0,0, 1,12'h801,8'h02,8'h03));
        tbl.push_back(mk(0,0,0,0, 1,12'h801,8'h02,8'h03));
        tbl.push_back(mk(0,0,0,0, 1,12'h801,8'h02,8'h03));
        tbl.push_back(mk(0,1,0,0, 1,12'h601,8'h03,8'h04));
        tbl.push_back(mk(0,1,0,0, 1,12'h700,8'h04,8'h05));
        // Test 3: redirect during a stall drops the held word
        tbl.push_back(mk(1,1,0,0, 1,12'h800,8'h00,8'h01));
        tbl.push_back(mk(0,1,0,0, 1,12'h600,8'h01,8'h02));
        tbl.push_back(mk(0,1,0,0, 1,12'h801,8'h02,8'h03));
        tbl.push_back(mk(0,0,0,0, 1,12'h801,8'h02,8'h03));
        tbl.push_back(mk(0,0,1,8'h09, 0,12'h000,8'h00,8'h09));
        tbl.push_back(mk(0,1,0,0, 1,12'h702,8'h09,8'h0A));
        tbl.push_back(mk(0,1,0,0, 1,12'h601,8'h0A,8'h0B));

        foreach (tbl[i]) begin
            if (tbl[i].restart) restart();
            bus.instr_ready    = tbl[i].ready;
            bus.redirect_valid = tbl[i].redir;
            bus.redirect_addr  = tbl[i].raddr;
            step();
            $display("vec %0d: valid=%0b instr=%03h pc=%02h rom_addr=%02h",
                     i, bus.instr_valid, bus.instr, bus.instr_pc, bus.rom_addr);
            chk($sformatf("vec%0d_valid", i), 32'(bus.instr_valid), 32'(tbl[i].ev));
            chk($sformatf("vec%0d_rom_addr", i), 32'(bus.rom_addr), 32'(tbl[i].era));
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d_instr", i), 32'(bus.instr), 32'(tbl[i].ei));
                chk($sformatf("vec%0d_instr_pc", i), 32'(bus.instr_pc), 32'(tbl[i].ep));
            end
        end
        bus.redirect_valid = 1'b0;

        // Test 4: halt at 0x05, then resume via redirect
        rom[5] = 12'hF00;
        restart();
        repeat (5) step();
        $display("halt: last word instr=%03h pc=%02h", bus.instr, bus.instr_pc);
        chk("halt_pre_instr", 32'(bus.instr), 32'h700);
        chk("halt_pre_pc", 32'(bus.instr_pc), 32'h04);
        chk("halt_pre_valid", 32'(bus.instr_valid), 1);
        step();
        $display("halt: halted=%0b busy=%0b rom_addr=%02h", halted, busy, bus.rom_addr);
        chk("halt_halted", 32'(halted), 1);
        chk("halt_busy", 32'(busy), 0);
        chk("halt_valid", 32'(bus.instr_valid), 0);
        chk("halt_count", 32'(fetch_count), 5);
        repeat (3) begin
            step();
            chk("halt_hold_valid", 32'(bus.instr_valid), 0);
            chk("halt_hold_rom_addr", 32'(bus.rom_addr), 32'h05);
        end
        bus.redirect_valid = 1'b1; bus.redirect_addr = 8'h00;
        step();
        bus.redirect_valid = 1'b0;
        chk("resume_busy", 32'(busy), 1);
        chk("resume_halted", 32'(halted), 0);
        chk("resume_rom_addr", 32'(bus.rom_addr), 0);
        step();
        $display("resume: instr=%03h pc=%02h", bus.instr, bus.instr_pc);
        chk("resume_instr", 32'(bus.instr), 32'h800);
        chk("resume_valid", 32'(bus.instr_valid), 1);
        chk("resume_count", 32'(fetch_count), 6);
        rom[5] = 12'h001;

        // Test 5: wrap from 0xFF to 0x00
        rom[8'hFF] = 12'h123;
        restart();
        bus.redirect_valid = 1'b1; bus.redirect_addr = 8'hFF;
        step();
        bus.redirect_valid = 1'b0;
        chk("wrap_rom_addr", 32'(bus.rom_addr), 32'hFF);
        step();
        $display("wrap: instr=%03h pc=%02h", bus.instr, bus.instr_pc);
        chk("wrap_instr_ff", 32'(bus.instr), 32'h123);
        chk("wrap_pc_ff", 32'(bus.instr_pc), 32'hFF);
        step();
        $display("wrap: instr=%03h pc=%02h", bus.instr, bus.instr_pc);
        chk("wrap_instr_00", 32'(bus.instr), 32'h800);
        chk("wrap_pc_00", 32'(bus.instr_pc), 32'h00);
        rom[8'hFF] = 12'h000;

        // Test 6a: asynchronous reset mid-run
        restart();
        repeat (3) step();
        chk("midrst_pre_valid", 32'(bus.instr_valid), 1);
        rst_n = 1'b0;
        #2;
        $display("midrst: valid=%0b instr=%03h busy=%0b", bus.instr_valid, bus.instr, busy);
        chk("midrst_valid", 32'(bus.instr_valid), 0);
        chk("midrst_instr", 32'(bus.instr), 0);
        chk("midrst_instr_pc", 32'(bus.instr_pc), 0);
        chk("midrst_rom_addr", 32'(bus.rom_addr), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_count", 32'(fetch_count), 0);
        rst_n = 1'b1;
        step();
        chk("midrst_idle_valid", 32'(bus.instr_valid), 0);

        // Test 6b: start is ignored in RUN
        restart();
        repeat (3) step();
        start = 1'b1;
        step();
        start = 1'b0;
        $display("start_in_run: instr=%03h pc=%02h", bus.instr, bus.instr_pc);
        chk("start_run_instr", 32'(bus.instr), 32'h601);
        chk("start_run_pc", 32'(bus.instr_pc), 32'h03);

        // Test 6c: fetch_count saturation (all-zero ROM, every word emitted)
        for (int i = 0; i < 256; i++) rom[i] = 12'h000;
        restart();
        repeat (1022) step();
        chk("sat_1022", 32'(fetch_count), 1022);
        step();
        chk("sat_1023", 32'(fetch_count), 1023);
        repeat (5) step();
        $display("sat: count=%0d instr_pc=%02h", fetch_count, bus.instr_pc);
        chk("sat_hold", 32'(fetch_count), 1023);
        chk("sat_instr_pc", 32'(bus.instr_pc), 32'h03);

        // Random traffic against the program-walk model
        for (int i = 0; i < 256; i++) begin
            int r;
            r = $urandom % 16;
            if (r < 1) begin
                rom[i] = 12'hF00;
            end else if (r < 3) begin
                rom[i] = {4'h4, 8'($urandom)};
            end else begin
                int op;
                op = $urandom_range(0, 13);
                if (op >= 4) op++;
                rom[i] = {4'(op), 8'($urandom)};
            end
        end
        restart();
        begin
            logic [7:0] m_pc;
            logic [7:0] at;
            int code;
            bit acc, rv;
            m_pc = 8'h00;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                bus.instr_ready    = ($urandom % 4) != 0;
                rv                 = ($urandom % 16) == 0;
                bus.redirect_valid = rv;
                bus.redirect_addr  = 8'($urandom);
                start              = ($urandom % 32) == 0;
                chk("rnd_busy_vs_halted", 32'(busy), 32'(!halted));
                if (halted) begin
                    code = walk_peek(m_pc, at);
                    chk("rnd_halt_expected", 32'(code), 2);
                    chk("rnd_halt_valid", 32'(bus.instr_valid), 0);
                    chk("rnd_halt_rom_addr", 32'(bus.rom_addr), 32'(at));
                end
                acc = bus.instr_valid && bus.instr_ready && !rv;
                if (acc) begin
                    code = walk_peek(m_pc, at);
                    $display("rnd accept: instr=%03h pc=%02h", bus.instr, bus.instr_pc);
                    chk("rnd_emit_expected", 32'(code), 1);
                    chk("rnd_instr", 32'(bus.instr), 32'(rom[at]));
                    chk("rnd_instr_pc", 32'(bus.instr_pc), 32'(at));
                    m_pc = at + 8'd1;
                end
                if (rv) m_pc = bus.redirect_addr;
                step();
            end
            start = 1'b0;
            bus.redirect_valid = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
